// File: rtl/wave_capture_pkg.sv
// Shared encodings for the multi-channel wave capture block.
// Capture states and trigger slope selection.
package wave_capture_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'b00,
        ACTIVE = 2'b01,
        WAIT   = 2'b10
    } state_t;

    localparam logic SLOPE_RISING  = 1'b0;
    localparam logic SLOPE_FALLING = 1'b1;

endpackage

// File: rtl/wave_capture_mc_if.sv
// Sample-stream / display-RAM bundle of the wave capture block.
// slave = capture block side, master = stream source / RAM side.
interface wave_capture_mc_if #(
    parameter int SAMPLE_W   = 16,
    parameter int OUT_W      = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int NUM_CH     = 2,
    parameter int CH_SEL_W   = 1
);
    logic                         new_sample_ready;
    logic [NUM_CH*SAMPLE_W-1:0]   new_sample_in;
    logic [CH_SEL_W-1:0]          ch_sel;
    logic [SAMPLE_W-1:0]          trig_level;
    logic                         trig_falling;
    logic                         wave_display_idle;
    logic [DEPTH_LOG2:0]          write_address;
    logic                         write_enable;
    logic [OUT_W-1:0]             write_sample;
    logic                         read_index;
    logic                         busy;
    logic                         capture_done;
    logic                         auto_triggered;

    modport slave (
        input  new_sample_ready, new_sample_in, ch_sel,
        input  trig_level, trig_falling, wave_display_idle,
        output write_address, write_enable, write_sample,
        output read_index, busy, capture_done, auto_triggered
    );

    modport master (
        output new_sample_ready, new_sample_in, ch_sel,
        output trig_level, trig_falling, wave_display_idle,
        input  write_address, write_enable, write_sample,
        input  read_index, busy, capture_done, auto_triggered
    );
endinterface

// File: rtl/wave_capture_mc_dff.sv
// Flop cells with synchronous active-low reset: dffr (plain)
// and dffre (load enable).
module dffr #(
    parameter int             W   = 1,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) o_q <= RST;
        else          o_q <= i_d;
    end
endmodule

module dffre #(
    parameter int             W   = 1,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)  o_q <= RST;
        else if (i_en) o_q <= i_d;
    end
endmodule

// File: rtl/wave_capture_mc_level_trigger.sv
// Level-crossing detector: remembers the previous sample of the
// watched channel and pulses o_trig on a signed threshold crossing.
module level_trigger
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clr,
    input  logic                       i_strobe,
    input  logic signed [SAMPLE_W-1:0] i_cur,
    input  logic signed [SAMPLE_W-1:0] i_level,
    input  logic                       i_slope,
    output logic                       o_trig
);
    logic signed [SAMPLE_W-1:0] r_prev;
    logic                       r_prev_valid;
    logic                       w_prev_valid_d;
    logic                       w_rise;
    logic                       w_fall;

    dffre #(.W(SAMPLE_W)) u_prev (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_strobe),
        .i_d     (i_cur),
        .o_q     (r_prev)
    );

    // A channel change on re-arm makes the old history meaningless.
    assign w_prev_valid_d = i_clr ? 1'b0 : (r_prev_valid | i_strobe);

    dffr #(.W(1)) u_prev_valid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_prev_valid_d),
        .o_q     (r_prev_valid)
    );

    assign w_rise = (r_prev <  i_level) && (i_cur >= i_level);
    assign w_fall = (r_prev >= i_level) && (i_cur <  i_level);

    assign o_trig = i_strobe & r_prev_valid &
                    ((i_slope == SLOPE_FALLING) ? w_fall : w_rise);
endmodule

// File: rtl/wave_capture_mc.sv
// Multi-channel triggered capture into a ping-pong display RAM.
// Optional forced trigger on timeout: WAVE_CAPTURE_AUTO_TRIG_EN.
module wave_capture_mc
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int OUT_W      = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int NUM_CH     = 2,
    parameter int CH_SEL_W   = 1
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    ,
    parameter int AUTO_TIMEOUT = 1024
`endif
) (
    input  logic             clk,
    input  logic             reset,
    wave_capture_mc_if.slave bus
);
    logic [1:0]                 r_state, w_state_d;
    logic [DEPTH_LOG2-1:0]      r_count, w_count_d;
    logic                       r_read_index, w_read_index_d;
    logic [CH_SEL_W-1:0]        r_ch_lat, w_ch_lat_d;
    logic                       r_rel;
    logic                       r_done, w_done_d;
    logic                       w_auto_out;
    logic signed [SAMPLE_W-1:0] w_cur;
    logic signed [SAMPLE_W-1:0] w_level;
    logic [OUT_W-1:0]           w_top;
    logic                       w_real_trig, w_force, w_fire;
    logic                       w_rearm, w_we;

    always_comb begin
        w_cur = bus.new_sample_in[SAMPLE_W-1:0];
        for (int k = 0; k < NUM_CH; k++)
            if (r_ch_lat == CH_SEL_W'(k))
                w_cur = bus.new_sample_in[k*SAMPLE_W +: SAMPLE_W];
    end

    assign w_level = bus.trig_level;
    assign w_rearm = (r_state == WAIT) & bus.wave_display_idle;

    level_trigger #(.SAMPLE_W(SAMPLE_W)) u_trig (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_clr    (w_rearm),
        .i_strobe (bus.new_sample_ready),
        .i_cur    (w_cur),
        .i_level  (w_level),
        .i_slope  (bus.trig_falling),
        .o_trig   (w_real_trig)
    );

    assign w_fire = w_real_trig | w_force;

    always_comb begin
        w_state_d      = r_state;
        w_count_d      = r_count;
        w_read_index_d = r_read_index;
        w_done_d       = 1'b0;
        w_we           = 1'b0;
        case (r_state)
            ARMED: begin
                if (w_fire) begin
                    w_we      = 1'b1;
                    w_count_d = DEPTH_LOG2'(1);
                    w_state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.new_sample_ready) begin
                    w_we      = 1'b1;
                    w_count_d = r_count + 1'b1;
                    if (&r_count) begin
                        w_state_d = WAIT;
                        w_done_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (bus.wave_display_idle) begin
                    w_read_index_d = ~r_read_index;
                    w_state_d      = ARMED;
                end
            end
            default: begin
                w_state_d = ARMED;
                w_count_d = '0;
            end
        endcase
    end

    // Channel is latched only at arm points so a capture stays coherent.
    assign w_ch_lat_d = (r_rel | w_rearm) ? bus.ch_sel : r_ch_lat;

    dffr #(.W(2), .RST(ARMED)) u_state (
        .i_clk (clk), .i_rst_n (reset), .i_d (w_state_d), .o_q (r_state)
    );
    dffr #(.W(DEPTH_LOG2)) u_count (
        .i_clk (clk), .i_rst_n (reset), .i_d (w_count_d), .o_q (r_count)
    );
    dffr #(.W(1)) u_rdidx (
        .i_clk (clk), .i_rst_n (reset), .i_d (w_read_index_d),
        .o_q (r_read_index)
    );
    dffr #(.W(CH_SEL_W)) u_chlat (
        .i_clk (clk), .i_rst_n (reset), .i_d (w_ch_lat_d), .o_q (r_ch_lat)
    );
    dffr #(.W(1), .RST(1'b1)) u_rel (
        .i_clk (clk), .i_rst_n (reset), .i_d (1'b0), .o_q (r_rel)
    );
    dffr #(.W(1)) u_done (
        .i_clk (clk), .i_rst_n (reset), .i_d (w_done_d), .o_q (r_done)
    );

`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT) + 1;

    logic [TO_W-1:0] r_to, w_to_d;
    logic            r_auto, w_auto_d;

    // Counter only runs while armed; leaving ARMED clears it.
    always_comb begin
        w_to_d = '0;
        if (r_state == ARMED)
            w_to_d = r_to + TO_W'(bus.new_sample_ready);
    end

    assign w_force = (r_state == ARMED) & bus.new_sample_ready &
                     ~w_real_trig &
                     (r_to == TO_W'(AUTO_TIMEOUT - 1));

    always_comb begin
        w_auto_d = r_auto;
        if ((r_state == ARMED) && w_fire)
            w_auto_d = w_force;
    end

    dffr #(.W(TO_W)) u_to (
        .i_clk (clk), .i_rst_n (reset), .i_d (w_to_d), .o_q (r_to)
    );
    dffr #(.W(1)) u_auto (
        .i_clk (clk), .i_rst_n (reset), .i_d (w_auto_d), .o_q (r_auto)
    );

    assign w_auto_out = r_auto;
`else
    assign w_force    = 1'b0;
    assign w_auto_out = 1'b0;
`endif

    assign w_top = w_cur[SAMPLE_W-1 -: OUT_W];

    assign bus.write_address  = {~r_read_index, r_count};
    assign bus.write_enable   = reset & w_we;
    assign bus.write_sample   = {~w_top[OUT_W-1], w_top[OUT_W-2:0]};
    assign bus.read_index     = r_read_index;
    assign bus.busy           = (r_state == ACTIVE) | (r_state == WAIT);
    assign bus.capture_done   = r_done;
    assign bus.auto_triggered = w_auto_out;
endmodule

// File: tb/tb_wave_capture_mc.sv
// Self-checking bench for wave_capture_mc: directed scenarios plus
// randomized captures scored against a stream-level reference model.
module tb_wave_capture_mc;
    localparam int SAMPLE_W   = 16;
    localparam int OUT_W      = 8;
    localparam int DEPTH_LOG2 = 8;
    localparam int NUM_CH     = 2;
    localparam int CH_SEL_W   = 1;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    localparam int AUTO_TO    = 16;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wave_capture_mc_if #(
        .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .DEPTH_LOG2(DEPTH_LOG2),
        .NUM_CH(NUM_CH), .CH_SEL_W(CH_SEL_W)
    ) bus ();

    wave_capture_mc #(
        .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .DEPTH_LOG2(DEPTH_LOG2),
        .NUM_CH(NUM_CH), .CH_SEL_W(CH_SEL_W)
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
        , .AUTO_TIMEOUT(AUTO_TO)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic m_ri   = 1'b0;
    logic m_auto = 1'b0;
    logic [NUM_CH*SAMPLE_W-1:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int sval(input logic [NUM_CH*SAMPLE_W-1:0] v,
                                input int ch);
        logic signed [SAMPLE_W-1:0] s;
        s = v[ch*SAMPLE_W +: SAMPLE_W];
        return int'(s);
    endfunction

    // Offset binary: top OUT_W bits of the sample plus half scale.
    function automatic logic [OUT_W-1:0] conv(input int x);
        int v;
        v = x >>> (SAMPLE_W - OUT_W);
        return OUT_W'(v + (1 << (OUT_W - 1)));
    endfunction

    task automatic push(input int ch, input int val);
        logic [NUM_CH*SAMPLE_W-1:0] v;
        for (int k = 0; k < NUM_CH; k++)
            v[k*SAMPLE_W +: SAMPLE_W] = (k == ch) ? SAMPLE_W'(val)
                                                  : SAMPLE_W'($urandom);
        q.push_back(v);
    endtask

    // First sample index that starts a capture for the queued stream.
    task automatic find_t(input int ch, input int lvl, input bit fall,
                          output int t, output bit forced);
        t = -1;
        forced = 1'b0;
        for (int i = 1; i < q.size(); i++) begin
            int p, c;
            p = sval(q[i-1], ch);
            c = sval(q[i], ch);
            if (t < 0 && (fall ? (p >= lvl && c < lvl)
                               : (p < lvl && c >= lvl)))
                t = i;
        end
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
        if ((t < 0 || t > AUTO_TO - 1) && q.size() >= AUTO_TO) begin
            t = AUTO_TO - 1;
            forced = 1'b1;
        end
`endif
    endtask

    task automatic run_capture(input int ch, input int lvl,
                               input bit fall, output int t);
        bit forced;
        bit wr;
        logic [DEPTH_LOG2:0] ea;
        find_t(ch, lvl, fall, t, forced);
        bus.trig_level   = SAMPLE_W'(lvl);
        bus.trig_falling = fall;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            bus.new_sample_ready = 1'b1;
            bus.new_sample_in    = q[i];
            #1;
            wr = (t >= 0) && (i >= t) && (i < t + DEPTH);
            chk("we", 64'(bus.write_enable), 64'(wr));
            if (wr) begin
                ea = {~m_ri, DEPTH_LOG2'(i - t)};
                chk("addr", 64'(bus.write_address), 64'(ea));
                chk("data", 64'(bus.write_sample), 64'(conv(sval(q[i], ch))));
            end
            @(negedge clk);
            bus.new_sample_ready = 1'b0;
            #1;
            if (t >= 0 && i == t) m_auto = forced;
            chk("we_gap", 64'(bus.write_enable), 64'(0));
            chk("done", 64'(bus.capture_done),
                64'(t >= 0 && i == t + DEPTH - 1));
            chk("busy", 64'(bus.busy), 64'(t >= 0 && i >= t));
            chk("auto", 64'(bus.auto_triggered), 64'(m_auto));
            chk("rdidx", 64'(bus.read_index), 64'(m_ri));
        end
        q.delete();
    endtask

    task automatic do_reset(input int ch);
        @(negedge clk);
        reset = 1'b0;
        bus.new_sample_ready = 1'b1;
        bus.new_sample_in = {$urandom, $urandom};
        #1;
        chk("we_in_reset", 64'(bus.write_enable), 64'(0));
        repeat (2) @(negedge clk);
        bus.new_sample_ready = 1'b0;
        bus.ch_sel = CH_SEL_W'(ch);
        reset = 1'b1;
        m_ri = 1'b0;
        m_auto = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_busy", 64'(bus.busy), 64'(0));
            chk("rst_rdidx", 64'(bus.read_index), 64'(0));
            chk("rst_done", 64'(bus.capture_done), 64'(0));
            chk("rst_auto", 64'(bus.auto_triggered), 64'(0));
        end
    endtask

    task automatic rearm(input int ch);
        @(negedge clk);
        bus.ch_sel = CH_SEL_W'(ch);
        bus.wave_display_idle = 1'b1;
        @(negedge clk);
        bus.wave_display_idle = 1'b0;
        m_ri = ~m_ri;
        #1;
        chk("rearm_rdidx", 64'(bus.read_index), 64'(m_ri));
        chk("rearm_busy", 64'(bus.busy), 64'(0));
    endtask

    task automatic build_rand(input int ch, input int lvl, input bit fall);
        int p;
        p = $urandom_range(1, 20);
        for (int i = 0; i < p; i++)
            push(ch, lvl + int'($urandom_range(0, 200)) - 100);
        push(ch, fall ? lvl : lvl - 1);
        push(ch, fall ? lvl - 1 : lvl);
        for (int i = 0; i < DEPTH + 2; i++)
            push(ch, lvl + int'($urandom_range(0, 200)) - 100);
    endtask

    initial begin
        int t;
        int ch;
        int lvl;
        bit fall;

        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.ch_sel            = 1'b1;
        bus.trig_level        = '0;
        bus.trig_falling      = 1'b0;
        bus.wave_display_idle = 1'b0;

        do_reset(1);

        // One sample after reset has no predecessor: no trigger.
        push(1, 100);
        run_capture(1, 0, 1'b0, t);
        chk("single_t", 64'(t), 64'(-1));
        do_reset(1);

        // Rising on ch1: -5, -1, +3 fires on +3.
        push(1, -5);
        push(1, -1);
        push(1, 3);
        for (int i = 0; i < DEPTH; i++)
            push(1, int'($urandom_range(0, 60000)) - 30000);
        run_capture(1, 0, 1'b0, t);
        chk("rise_t", 64'(t), 64'(2));

        // Display busy: no writes, no swap while idle stays low.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            bus.new_sample_ready = 1'($urandom);
            bus.new_sample_in = {$urandom, $urandom};
            #1;
            chk("wait_we", 64'(bus.write_enable), 64'(0));
            chk("wait_rdidx", 64'(bus.read_index), 64'(0));
            chk("wait_busy", 64'(bus.busy), 64'(1));
        end
        @(negedge clk);
        bus.new_sample_ready = 1'b0;

        // Falling on ch0 at 0x1000; ch1 noise must not matter.
        rearm(0);
        push(0, 'h2000);
        push(0, 'h0FFF);
        for (int i = 0; i < DEPTH; i++)
            push(0, int'($urandom_range(0, 'h3000)));
        run_capture(0, 'h1000, 1'b1, t);
        chk("fall_t", 64'(t), 64'(1));

        // Below then above: fires on the second sample.
        rearm(1);
        push(1, -10);
        push(1, 10);
        for (int i = 0; i < DEPTH; i++)
            push(1, int'($urandom_range(0, 200)) - 100);
        run_capture(1, 0, 1'b0, t);
        chk("second_t", 64'(t), 64'(1));

        for (int n = 0; n < 4; n++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            lvl = int'($urandom_range(0, 40000)) - 20000;
            fall = 1'($urandom);
            rearm(ch);
            build_rand(ch, lvl, fall);
            run_capture(ch, lvl, fall, t);
            chk("rand_t", 64'(t >= 0), 64'(1));
        end

        // Abandon a capture at count 100.
        rearm(0);
        push(0, -50);
        push(0, 50);
        for (int i = 0; i < 99; i++)
            push(0, int'($urandom_range(0, 200)) - 100);
        run_capture(0, 0, 1'b0, t);
        chk("abort_t", 64'(t), 64'(1));
        do_reset(0);
        build_rand(0, 500, 1'b0);
        run_capture(0, 500, 1'b0, t);
        chk("post_rst_t", 64'(t >= 0), 64'(1));

`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
        rearm(1);
        for (int i = 0; i < AUTO_TO + DEPTH + 1; i++)
            push(1, 0);
        run_capture(1, 100, 1'b0, t);
        chk("auto_t", 64'(t), 64'(AUTO_TO - 1));
        chk("auto_set", 64'(bus.auto_triggered), 64'(1));
        rearm(1);
        build_rand(1, 0, 1'b0);
        run_capture(1, 0, 1'b0, t);
        chk("auto_clr", 64'(bus.auto_triggered), 64'(0));
`else
        // Flat input never crosses and nothing is forced.
        rearm(1);
        for (int i = 0; i < 40; i++)
            push(1, 0);
        run_capture(1, 100, 1'b0, t);
        chk("flat_t", 64'(t), 64'(-1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wave_capture_mc.md
Name: wave_capture_mc

Overview:
Parametrised multi-channel successor to the single-channel scope capture block. It watches one selected channel of a packed sample bus for a level crossing with programmable threshold and slope. On a crossing it writes 2^DEPTH_LOG2 converted samples into the half of a ping-pong sample RAM that the display is not reading, then waits for the display to go idle and swaps halves. It sits between the codec sample stream and the wave display RAM.

Parameters:
SAMPLE_W, 16, width of one signed input sample
OUT_W, 8, width of stored sample (OUT_W <= SAMPLE_W)
DEPTH_LOG2, 8, log2 of samples per capture (per RAM half)
NUM_CH, 2, number of packed input channels (>= 2)
CH_SEL_W, 1, width of ch_sel; equals $clog2(NUM_CH)
AUTO_TIMEOUT, 1024, samples in ARMED before forced trigger (used only with AUTO_TRIG_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
new_sample_ready  in  1  one-cycle strobe; all channels valid this cycle
new_sample_in  in  NUM_CH*SAMPLE_W  packed two's-complement samples; channel k at [k*SAMPLE_W +: SAMPLE_W]
ch_sel  in  CH_SEL_W  channel to trigger on and capture
trig_level  in  SAMPLE_W  signed trigger threshold
trig_falling  in  1  0 = rising-crossing trigger, 1 = falling-crossing trigger
wave_display_idle  in  1  display is between frames; halves may be swapped
write_address  out  DEPTH_LOG2+1  {~read_index, sample_count}
write_enable  out  1  RAM write strobe
write_sample  out  OUT_W  converted sample
read_index  out  1  RAM half the display reads
busy  out  1  high in ACTIVE or WAIT
capture_done  out  1  one-cycle pulse on ACTIVE->WAIT
auto_triggered  out  1  current/last capture was forced by timeout

Behaviour:
- Reset (reset==0 at a clk edge): state ARMED, count 0, read_index 0, prev_valid 0, ch_lat 0, capture_done 0, auto_triggered 0. write_enable is forced 0 while reset is low.
- ch_lat: ch_sel is registered on reset release and on every WAIT->ARMED transition. Changes to ch_sel at any other time are ignored.
- cur = channel ch_lat of new_sample_in. prev is a register updated with cur on every new_sample_ready, in any state. prev_valid is set by the first update and cleared on reset and on WAIT->ARMED.
- Trigger (evaluated only when new_sample_ready=1 and prev_valid=1), using signed compares:
  - rising: prev < trig_level && cur >= trig_level
  - falling: prev >= trig_level && cur < trig_level
- States:
  - ARMED: on trigger, write cur at count 0 (write_enable=1 this cycle), set count to 1, go to ACTIVE.
  - ACTIVE: each new_sample_ready writes cur at count, then count increments. The write at count 2^DEPTH_LOG2-1 goes to WAIT, wraps count to 0 and pulses capture_done in the following cycle.
  - WAIT: no writes. When wave_display_idle=1, toggle read_index and go to ARMED in the same edge.
- wave_display_idle is ignored in ARMED and ACTIVE. Triggers are ignored in ACTIVE and WAIT.
- write_address, write_enable and write_sample are combinational from the current state, count, read_index and inputs. Write latency is 0 cycles.
- Conversion: write_sample = cur[SAMPLE_W-1 -: OUT_W] with MSB inverted. This is offset binary, i.e. +2^(OUT_W-1) modulo 2^OUT_W. No rounding.
- Reset asserted mid-capture: partial buffer is abandoned, read_index returns to 0, no capture_done.
- Illegal state encoding: recover to ARMED with count 0.

Optional Feature:
WAVE_CAPTURE_AUTO_TRIG_EN
- Defined: a timeout counter clears on entering ARMED and increments on each new_sample_ready in ARMED. On the sample where it reaches AUTO_TIMEOUT-1 with no real trigger, a forced trigger occurs (same behaviour as a real trigger). auto_triggered is set on a forced trigger and cleared on a real trigger.
- Undefined: no counter is built, and auto_triggered is tied 0.

Decomposition:
- Shared package wave_capture_pkg: state encoding constants ARMED=2'b00, ACTIVE=2'b01, WAIT=2'b10, and the slope encodings.
- Sub-module: level_trigger. It contains the prev/prev_valid registers plus the slope compare, and outputs a single trig pulse.
- The existing dffr/dffre flop cells are used for all state.

Test Plan:
- Rising trigger: ch_sel=1, trig_level=0, ch1 samples -5,-1,+3 → write at addr {1,0} with sample +3 (0x80 after conversion); 255 further writes to addr {1,1..255}; capture_done pulse; busy=1 until idle.
- Falling trigger: trig_falling=1, level=0x1000, ch0 samples 0x2000 then 0x0FFF → trigger on 0x0FFF; ch1 activity produces no trigger.
- First sample after reset is below level, second above → trigger fires on the second sample only; a single sample after reset never triggers.
- WAIT with wave_display_idle held 0 for 500 cycles → no writes, read_index stays 0; idle=1 → read_index=1 next edge, ARMED; the next capture writes addresses 0..255.
- Reset driven low at count=100 → next cycle ARMED, count 0, read_index 0, write_enable 0, no capture_done.
- AUTO_TRIG_EN with AUTO_TIMEOUT=16 and a constant input → capture starts on the 16th sample with auto_triggered=1; a real crossing on the next arm clears it.
